// File: rtl/bcd_counter_ndigit_updown_if.sv
// Control, load and display signals of the N-digit up/down BCD counter.
// The counter takes the slave side; whatever drives it takes the master side.
interface bcd_counter_ndigit_updown_if #(
  parameter int DIGITS = 2
);
  logic                  C;
  logic                  S;
  logic                  En;
  logic                  Up;
  logic [4*DIGITS-1:0]   In;
  logic [4*DIGITS-1:0]   Out;
  logic [7*DIGITS-1:0]   SSD_out;
  logic                  Tc;
  logic                  Ovf;

  modport master (
    output C, S, En, Up, In,
    input  Out, SSD_out, Tc, Ovf
  );

  modport slave (
    input  C, S, En, Up, In,
    output Out, SSD_out, Tc, Ovf
  );
endinterface

// File: rtl/bcd_counter_ndigit_updown.sv
// Cascaded N-digit BCD up/down counter, updated on the falling clock edge,
// with active-low seven-segment decode and optional leading-zero blanking.
module bcd_counter_ndigit_updown #(
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 0
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  bcd_counter_ndigit_updown_if.slave   cnt_if
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]          cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  all9, all0;
  logic [7*DIGITS-1:0]   ssd;

  function automatic logic [3:0] sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next state: clear beats load beats count; carry/borrow ripples through
  // all digits in one edge, and a carry out of the top digit is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    carry = 1'b1;
    dig   = 4'd0;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (cnt_if.C) begin
      cnt_d = '0;
    end else if (cnt_if.S) begin
      for (int k = 0; k < DIGITS; k++)
        cnt_d[4*k +: 4] = sanitize(cnt_if.In[4*k +: 4]);
    end else if (cnt_if.En) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = cnt_q[4*k +: 4];
        if (carry) begin
          if (cnt_if.Up) begin
            if (dig == 4'd9) cnt_d[4*k +: 4] = 4'd0;
            else begin
              cnt_d[4*k +: 4] = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) cnt_d[4*k +: 4] = 4'd9;
            else begin
              cnt_d[4*k +: 4] = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      ovf_d = carry;
    end
  end

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      all9 = all9 & (cnt_q[4*k +: 4] == 4'd9);
      all0 = all0 & (cnt_q[4*k +: 4] == 4'd0);
    end
  end

  // Scan from the top digit down; a digit is blanked while nothing nonzero
  // has been seen at or above it, except digit 0 which always shows.
  always_comb begin
    logic       seen;
    logic [3:0] dig;
    seen = 1'b0;
    dig  = 4'd0;
    ssd  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig  = cnt_q[4*k +: 4];
      seen = seen | (dig != 4'd0);
      if ((BLANK_LZ != 0) && (k != 0) && !seen)
        ssd[7*k +: 7] = 7'b1111111;
      else
        ssd[7*k +: 7] = seg7(dig);
    end
  end

  assign cnt_if.Out     = cnt_q;
  assign cnt_if.Ovf     = ovf_q;
  assign cnt_if.SSD_out = ssd;
  assign cnt_if.Tc      = cnt_if.En & (cnt_if.Up ? all9 : all0);

endmodule

// File: tb/tb_bcd_counter_ndigit_updown.sv
// Bench for the N-digit BCD counter: directed scenarios plus random traffic,
// compared against an integer-valued model of the count.
module tb_bcd_counter_ndigit_updown;

  localparam int MOD = 100;
  localparam logic [6:0] SEG_TBL [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  bcd_counter_ndigit_updown_if #(.DIGITS(2)) a_if ();
  bcd_counter_ndigit_updown_if #(.DIGITS(3)) b_if ();

  bcd_counter_ndigit_updown #(.DIGITS(2), .BLANK_LZ(0)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .cnt_if(a_if)
  );
  bcd_counter_ndigit_updown #(.DIGITS(3), .BLANK_LZ(1)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .cnt_if(b_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_val    = 0;
  logic m_ovf    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int v, input int nd);
    logic [63:0] r = '0;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ssd_ref(input int v, input int nd, input bit blank);
    logic [63:0] r = '0;
    int p = 1;
    for (int k = 0; k < nd; k++) begin
      if (blank && k > 0 && v < p) r[7*k +: 7] = 7'h7F;
      else                         r[7*k +: 7] = SEG_TBL[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_val(input logic [7:0] ld);
    int d0 = int'(ld[3:0]);
    int d1 = int'(ld[7:4]);
    if (d0 > 9) d0 = 0;
    if (d1 > 9) d1 = 0;
    return d1 * 10 + d0;
  endfunction

  task automatic model_edge(input bit c, input bit s, input bit en, input bit up, input logic [7:0] ld);
    m_ovf = 1'b0;
    if (c) m_val = 0;
    else if (s) m_val = load_val(ld);
    else if (en) begin
      if (up) begin
        if (m_val == MOD - 1) begin m_val = 0; m_ovf = 1'b1; end
        else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin m_val = MOD - 1; m_ovf = 1'b1; end
        else m_val = m_val - 1;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_out"}, 64'(a_if.Out), to_bcd(m_val, 2));
    check({tag, "_ovf"}, 64'(a_if.Ovf), 64'(m_ovf));
    check({tag, "_ssd"}, 64'(a_if.SSD_out), ssd_ref(m_val, 2, 1'b0));
  endtask

  task automatic step(input bit c, input bit s, input bit en, input bit up,
                      input logic [7:0] ld, input string tag);
    bit tc_exp;
    @(posedge Clk);
    #1;
    a_if.C = c; a_if.S = s; a_if.En = en; a_if.Up = up; a_if.In = ld;
    #1;
    tc_exp = en && (up ? (m_val == MOD - 1) : (m_val == 0));
    check({tag, "_tc"}, 64'(a_if.Tc), 64'(tc_exp));
    @(negedge Clk);
    model_edge(c, s, en, up, ld);
    #1;
    check_outs(tag);
  endtask

  task automatic step_b(input bit c, input bit s, input logic [11:0] ld,
                        input int exp_val, input logic [20:0] exp_ssd, input string tag);
    @(posedge Clk);
    #1;
    b_if.C = c; b_if.S = s; b_if.In = ld;
    @(negedge Clk);
    #1;
    check({tag, "_out"}, 64'(b_if.Out), to_bcd(exp_val, 3));
    check({tag, "_ssd"}, 64'(b_if.SSD_out), 64'(exp_ssd));
    check({tag, "_ssdm"}, 64'(b_if.SSD_out), ssd_ref(exp_val, 3, 1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_if.C = 0; a_if.S = 0; a_if.En = 0; a_if.Up = 0; a_if.In = '0;
    b_if.C = 0; b_if.S = 0; b_if.En = 0; b_if.Up = 0; b_if.In = '0;
    Rst_n = 1'b0;
    #12;
    check_outs("rst");
    check("rst_tc", 64'(a_if.Tc), 64'd0);
    check("rst_b_ssd", 64'(b_if.SSD_out), {43'd0, 7'h7F, 7'h7F, 7'b0000001});
    Rst_n = 1'b1;

    // Three-digit instance with leading-zero blanking
    step_b(1'b0, 1'b1, 12'h007, 7,   {7'h7F, 7'h7F, 7'b0001111}, "b_ld007");
    step_b(1'b0, 1'b1, 12'h305, 305, {7'b0000110, 7'b0000001, 7'b0100100}, "b_ld305");
    step_b(1'b1, 1'b0, 12'h305, 0,   {7'h7F, 7'h7F, 7'b0000001}, "b_clr");
    b_if.C = 0;

    // Full up walk 00..99 then wrap
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "walk");

    // Down wrap from 00
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "ld00");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dnwrap");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "hold");

    // Invalid-digit load, then clear beating load
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, "ld3c");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, "clrld");

    // Direction toggled every edge
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h50, "ld50");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, (i % 2) == 0, 8'h00, "toggle");

    // Asynchronous reset mid-count
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "clr");
    for (int i = 0; i < 47; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "to47");
    check("at47", 64'(a_if.Out), 64'h47);
    @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    m_val = 0; m_ovf = 1'b0;
    check_outs("arst");
    @(negedge Clk);
    #1;
    check_outs("arst_hold");
    Rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "resume");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit c, s, en, up;
      logic [7:0] ld;
      c  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) == 1;
      ld = 8'($urandom);
      step(c, s, en, up, ld, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
